// File: rtl/bcd_seg_display_seq_pkg.sv
// Shared types and constants for the sequential binary-to-7-segment display path.
package bcd_seg_display_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned NIB_W = 4;
    localparam logic [6:0] BLANK_PAT_DEF = 7'h7F;

    // Decimal digits needed to hold any W-bit unsigned value: floor(W*log10(2))+1.
    function automatic int unsigned calc_ni(input int unsigned w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_seg_display_seq_sevenseg.sv
// Nibble (0..F) to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module bcd_seg_display_seq_sevenseg (
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    // Pattern lookup
    always_comb begin
        seg_c = 7'h7F;
        case (nib)
            4'h0: seg_c = 7'h40;
            4'h1: seg_c = 7'h79;
            4'h2: seg_c = 7'h24;
            4'h3: seg_c = 7'h30;
            4'h4: seg_c = 7'h19;
            4'h5: seg_c = 7'h12;
            4'h6: seg_c = 7'h02;
            4'h7: seg_c = 7'h78;
            4'h8: seg_c = 7'h00;
            4'h9: seg_c = 7'h10;
            4'hA: seg_c = 7'h08;
            4'hB: seg_c = 7'h03;
            4'hC: seg_c = 7'h46;
            4'hD: seg_c = 7'h21;
            4'hE: seg_c = 7'h06;
            4'hF: seg_c = 7'h0E;
            default: seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/bcd_seg_display_seq.sv
// Sequential binary-to-display converter: double-dabble decimal or direct hex,
// held digits with overflow flag, leading-zero blanking, one 7-seg per digit.
module bcd_seg_display_seq
    import bcd_seg_display_seq_pkg::*;
#(
    parameter int unsigned W         = 32,
    parameter int unsigned DIGITS    = 6,
    parameter logic [6:0]  BLANK_PAT = BLANK_PAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          value,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned NI    = calc_ni(W);
    localparam int unsigned NX    = (NI > DIGITS) ? NI : DIGITS;
    localparam int unsigned CNT_W = $clog2(W + 1);
    localparam int unsigned HEX_W = 64;
    localparam int unsigned DIG_W = NIB_W * DIGITS;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [W-1:0]           sh;
    logic [NIB_W*NI-1:0]    bcd;
    logic                   hex_q;
    logic [DIG_W-1:0]       digits;

    logic [NIB_W*NI-1:0]    bcd_adj;
    logic [NIB_W*NI-1:0]    bcd_nxt;
    logic [W-1:0]           sh_nxt;
    logic [NIB_W*NX-1:0]    dec_ext;
    logic [HEX_W-1:0]       hex_ext;
    logic                   dec_ovf;
    logic                   hex_ovf;
    logic [DIGITS-1:0]      blank_c;

    // One double-dabble step: add-3 on nibbles >= 5, then shift {bcd,sh} left
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(NI); i++) begin
            if (bcd[NIB_W*i +: NIB_W] >= 4'd5)
                bcd_adj[NIB_W*i +: NIB_W] = bcd[NIB_W*i +: NIB_W] + 4'd3;
        end
        {bcd_nxt, sh_nxt} = {bcd_adj, sh} << 1;
    end

    assign dec_ext = (NIB_W*NX)'(bcd_nxt);
    assign hex_ext = HEX_W'(sh);
    assign dec_ovf = |(dec_ext >> DIG_W);
    assign hex_ovf = |(hex_ext >> DIG_W);

    // Control FSM, shift datapath and held display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sh       <= '0;
            bcd      <= '0;
            hex_q    <= 1'b0;
            digits   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (start) begin
                        sh    <= value;
                        hex_q <= hex_mode;
                        bcd   <= '0;
                        cnt   <= CNT_W'(W);
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (hex_q) begin
                        digits   <= hex_ext[DIG_W-1:0];
                        overflow <= hex_ovf;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        bcd <= bcd_nxt;
                        sh  <= sh_nxt;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            digits   <= dec_ext[DIG_W-1:0];
                            overflow <= dec_ovf;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Leading-zero blank flags: digit i blanked when it and all higher digits are zero
    always_comb begin
        logic run;
        run     = 1'b1;
        blank_c = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            run        = run & (digits[NIB_W*i +: NIB_W] == 4'd0);
            blank_c[i] = blank_lz & run & (i != 0);
        end
    end

    // Per-digit decoder with blanking mux
    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_dig
        logic [6:0] pat_c;
        bcd_seg_display_seq_sevenseg u_sevenseg (
            .nib   (digits[NIB_W*i +: NIB_W]),
            .seg_c (pat_c)
        );
        assign seg[7*i +: 7] = blank_c[i] ? BLANK_PAT : pat_c;
    end

endmodule

// File: tb/tb_bcd_seg_display_seq.sv
// Self-checking bench for bcd_seg_display_seq (W=32, DIGITS=6).
module tb_bcd_seg_display_seq;

    localparam int unsigned W      = 32;
    localparam int unsigned DIGITS = 6;
    localparam int          MAXLAT = 100;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic              clk;
    logic              rst;
    logic              start;
    logic [W-1:0]      value;
    logic              hex_mode;
    logic              blank_lz;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [7*DIGITS-1:0] seg;

    typedef struct {
        logic [23:0] d;
        logic        o;
    } exp_t;

    typedef struct {
        logic [31:0] v;
        logic        hx;
        logic        bl;
        logic [23:0] d;
        logic        o;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   fails  = 0;

    bcd_seg_display_seq #(.W(W), .DIGITS(DIGITS), .BLANK_PAT(7'h7F)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] exp_seg(input logic [23:0] d, input logic bl);
        logic [41:0] r;
        logic        lead;
        logic [3:0]  n;
        lead = 1'b1;
        r    = '0;
        for (int i = 5; i >= 0; i--) begin
            n = d[4*i +: 4];
            if (n != 4'd0) lead = 1'b0;
            r[7*i +: 7] = (bl && lead && i != 0) ? 7'h7F : SEG_TAB[n];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits for done, checking busy each cycle; lat counts edges since capture
    task automatic wait_done(input string nm, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < MAXLAT) begin
            chk({nm, "_busy"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Pops the scoreboard on the done cycle and compares the display
    task automatic check_result(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sbq.pop_front();
        chk({nm, "_done"},  64'(done),     64'd1);
        chk({nm, "_seg"},   64'(seg),      64'(exp_seg(e.d, blank_lz)));
        chk({nm, "_ovf"},   64'(overflow), 64'(e.o));
        chk({nm, "_busy0"}, 64'(busy),     64'd0);
    endtask

    task automatic conv(input string nm, input logic [31:0] v, input logic hx,
                        input logic [23:0] d, input logic o);
        int lat;
        @(negedge clk);
        value    = v;
        hex_mode = hx;
        start    = 1'b1;
        sbq.push_back('{d, o});
        @(posedge clk); #1;
        start = 1'b0;
        value = ~v;
        wait_done(nm, lat);
        chk({nm, "_lat"}, 64'(lat), hx ? 64'd1 : 64'(W));
        check_result(nm);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, 64'(done), 64'd0);
        chk({nm, "_hold"},  64'(seg),  64'(exp_seg(d, blank_lz)));
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        int nd;

        vecs[0]  = '{32'd123456,     1'b0, 1'b0, 24'h123456, 1'b0};
        vecs[1]  = '{32'd1234567,    1'b0, 1'b0, 24'h234567, 1'b1};
        vecs[2]  = '{32'd999999,     1'b0, 1'b0, 24'h999999, 1'b0};
        vecs[3]  = '{32'hFFFFFFFF,   1'b0, 1'b0, 24'h967295, 1'b1};
        vecs[4]  = '{32'd1000000,    1'b0, 1'b1, 24'h000000, 1'b1};
        vecs[5]  = '{32'h00ABCDEF,   1'b1, 1'b0, 24'hABCDEF, 1'b0};
        vecs[6]  = '{32'h01ABCDEF,   1'b1, 1'b1, 24'hABCDEF, 1'b1};
        vecs[7]  = '{32'd42,         1'b0, 1'b1, 24'h000042, 1'b0};
        vecs[8]  = '{32'd0,          1'b0, 1'b1, 24'h000000, 1'b0};
        vecs[9]  = '{32'h00000F00,   1'b1, 1'b1, 24'h000F00, 1'b0};
        vecs[10] = '{32'd7,          1'b0, 1'b1, 24'h000007, 1'b0};
        vecs[11] = '{32'd305419896,  1'b0, 1'b1, 24'h419896, 1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        value    = '0;
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_done", 64'(done),     64'd0);
        chk("rst_ovf",  64'(overflow), 64'd0);
        chk("rst_seg",  64'(seg),      64'(exp_seg(24'h0, 1'b0)));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven conversions
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            blank_lz = vecs[i].bl;
            conv($sformatf("vec%0d", i), vecs[i].v, vecs[i].hx, vecs[i].d, vecs[i].o);
        end

        // blank_lz is live: display changes in the same cycle, no done
        blank_lz = 1'b0;
        conv("b42", 32'd42, 1'b0, 24'h000042, 1'b0);
        @(negedge clk);
        blank_lz = 1'b1;
        #1;
        chk("blank_on_seg",  64'(seg),  64'(exp_seg(24'h000042, 1'b1)));
        chk("blank_on_done", 64'(done), 64'd0);
        @(negedge clk);
        blank_lz = 1'b0;
        #1;
        chk("blank_off_seg", 64'(seg),  64'(exp_seg(24'h000042, 1'b0)));

        // Start held high: one conversion per W+1 cycles, mid-SHIFT value change ignored
        @(negedge clk);
        value    = 32'd87654321;
        hex_mode = 1'b0;
        start    = 1'b1;
        sbq.push_back('{24'h654321, 1'b1});
        @(posedge clk); #1;
        value = 32'd999;
        wait_done("b2b_a", lat);
        chk("b2b_a_lat", 64'(lat), 64'(W));
        check_result("b2b_a");
        value = 32'd500;
        sbq.push_back('{24'h000500, 1'b0});
        @(posedge clk); #1;
        chk("b2b_accept_busy", 64'(busy), 64'd1);
        value = 32'd12345;
        wait_done("b2b_b", lat);
        chk("b2b_b_lat", 64'(lat), 64'(W));
        check_result("b2b_b");
        start = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a decimal conversion
        @(negedge clk);
        value = 32'd123456;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 64'(busy),     64'd0);
        chk("midrst_done", 64'(done),     64'd0);
        chk("midrst_ovf",  64'(overflow), 64'd0);
        chk("midrst_seg",  64'(seg),      64'(exp_seg(24'h0, 1'b0)));
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        chk("midrst_no_done", 64'(nd), 64'd0);
        conv("post_rst", 32'd123456, 1'b0, 24'h123456, 1'b0);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
